// File: rtl/pdp8_top.sv
// pdp8_top: single-clock PDP-8 processor with 4K x 12 word memory,
// instruction-cycle state machine and front-panel (switches, buttons,
// LEDs, 8-digit seven-segment display showing PC or AC in octal).
module pdp8_top (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        btnc,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnr,
  input  logic [12:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EA, S_IND, S_RD, S_AND, S_TAD, S_ISZ1, S_ISZ2,
    S_DCA, S_JMS1, S_JMS2, S_JMP, S_MIC
  } state_t;

  state_t      state_r;
  logic [11:0] pc_r, ac_r, mq_r, ir_r, mb_r, ea_r;
  logic        link_r, run_r, done_r, disp_sel_r;
  logic [4:0]  btn_q_r;
  logic        sw12_q_r;
  logic [15:0] scan_r;

  logic [11:0] mem_r [0:4095];
  logic [4095:0] valid_r;
  logic [11:0] rdata_r;

  logic [11:0] mem_addr_s, mem_wdata_s;
  logic        mem_we_s;

  logic [4:0]  btn_now_s, edge_s;
  logic        sw12_edge_s, panel_ok_s, dep_s, fin_s, hlt_s, auto_s, skip_s;
  logic [11:0] base_s, cla_ac_s, g2_ac_s, disp_val_s;
  logic [12:0] g1_s, tad_s;
  logic [2:0]  digit_s;
  logic [7:0]  an_s;

  // Group 1 operate: clear, complement, increment, then rotate of {L,AC}
  function automatic logic [12:0] opr1(input logic [11:0] i, input logic l,
                                       input logic [11:0] a);
    logic [12:0] t;
    logic [12:0] s;
    t = {l, a};
    if (i[7]) t[11:0] = 12'd0;
    if (i[6]) t[12] = 1'b0;
    if (i[5]) t[11:0] = ~t[11:0];
    if (i[4]) t[12] = ~t[12];
    if (i[0]) begin
      s = {1'b0, t[11:0]} + 13'd1;
      t = {t[12] ^ s[12], s[11:0]};
    end
    if (i[3]) begin
      t = i[1] ? {t[1:0], t[12:2]} : {t[0], t[12:1]};
    end else if (i[2]) begin
      t = i[1] ? {t[10:0], t[12:11]} : {t[11:0], t[12]};
    end
    return t;
  endfunction

  // Group 2 skip decision, taken on the AC and L as they were on entry
  function automatic logic g2_skip(input logic [11:0] i, input logic l,
                                   input logic [11:0] a);
    logic r;
    if (i[3]) begin
      r = (i[6] ? ~a[11] : 1'b1) & (i[5] ? (a != 12'd0) : 1'b1) &
          (i[4] ? ~l : 1'b1);
    end else begin
      r = (i[6] & a[11]) | (i[5] & (a == 12'd0)) | (i[4] & l);
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a} glyphs for octal digits
  function automatic logic [6:0] glyph(input logic [2:0] d);
    logic [6:0] g;
    case (d)
      3'd0:    g = 7'h40;
      3'd1:    g = 7'h79;
      3'd2:    g = 7'h24;
      3'd3:    g = 7'h30;
      3'd4:    g = 7'h19;
      3'd5:    g = 7'h12;
      3'd6:    g = 7'h02;
      3'd7:    g = 7'h78;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Panel edge detection, address decode and datapath helpers
  always_comb begin
    btn_now_s   = {btnc, btnu, btnd, btnl, btnr};
    edge_s      = btn_now_s & ~btn_q_r;
    sw12_edge_s = sw[12] & ~sw12_q_r;
    panel_ok_s  = (state_r == S_IDLE) && !run_r;
    dep_s       = panel_ok_s && !edge_s[3] && edge_s[2];
    base_s      = rdata_r[7] ? {pc_r[11:7], rdata_r[6:0]} : {5'd0, rdata_r[6:0]};
    auto_s      = (ea_r[11:3] == 9'd1);
    tad_s       = {1'b0, ac_r} + {1'b0, rdata_r};
    g1_s        = opr1(ir_r, link_r, ac_r);
    skip_s      = g2_skip(ir_r, link_r, ac_r);
    cla_ac_s    = ir_r[7] ? 12'd0 : ac_r;
    g2_ac_s     = ir_r[2] ? (cla_ac_s | sw[11:0]) : cla_ac_s;
    hlt_s       = (state_r == S_MIC) && (ir_r[11:9] == 3'd7) && ir_r[8] &&
                  !ir_r[0] && ir_r[1];
    case (state_r)
      S_AND, S_TAD, S_ISZ2, S_DCA, S_JMS2, S_JMP, S_MIC: fin_s = 1'b1;
      default:                                           fin_s = 1'b0;
    endcase
  end

  // Memory port control: one address, one write per cycle, writes blocked in reset
  always_comb begin
    mem_addr_s  = pc_r;
    mem_wdata_s = ac_r;
    mem_we_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (dep_s) begin
          mem_we_s    = 1'b1;
          mem_wdata_s = sw[11:0];
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      S_EA:   mem_addr_s = base_s;
      S_IND: begin
        mem_addr_s  = ea_r;
        mem_wdata_s = rdata_r + 12'd1;
        mem_we_s    = auto_s;
      end
      S_RD:   mem_addr_s = ea_r;
      S_ISZ2: begin
        mem_addr_s  = ea_r;
        mem_wdata_s = mb_r;
        mem_we_s    = 1'b1;
      end
      S_DCA: begin
        mem_addr_s  = ea_r;
        mem_wdata_s = ac_r;
        mem_we_s    = 1'b1;
      end
      S_JMS1: begin
        mem_addr_s  = ea_r;
        mem_wdata_s = pc_r;
        mem_we_s    = 1'b1;
      end
      default: mem_addr_s = pc_r;
    endcase
    if (btnCpuReset) mem_we_s = 1'b0;
    else             mem_we_s = mem_we_s;
  end

  // Word memory: synchronous read with one-cycle latency, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_r[mem_addr_s] <= mem_wdata_s;
    rdata_r <= mem_r[mem_addr_s];
  end

  // Per-word written flags, cleared by reset
  always_ff @(posedge clk) begin
    if (btnCpuReset) valid_r <= '0;
    else if (mem_we_s) valid_r[mem_addr_s] <= 1'b1;
  end

  // Instruction-cycle state machine, run control and panel actions
  always_ff @(posedge clk) begin
    if (btnCpuReset) begin
      state_r    <= S_IDLE;
      pc_r       <= 12'd0;
      ac_r       <= 12'd0;
      mq_r       <= 12'd0;
      ir_r       <= 12'd0;
      mb_r       <= 12'd0;
      ea_r       <= 12'd0;
      link_r     <= 1'b0;
      run_r      <= 1'b0;
      done_r     <= 1'b0;
      disp_sel_r <= 1'b0;
      btn_q_r    <= 5'd0;
      sw12_q_r   <= 1'b0;
    end else begin
      btn_q_r  <= btn_now_s;
      sw12_q_r <= sw[12];
      done_r   <= 1'b0;
      if (edge_s[4]) disp_sel_r <= ~disp_sel_r;
      if (sw12_edge_s) run_r <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (run_r) state_r <= S_FETCH;
          else if (edge_s[3]) state_r <= S_FETCH;
          else if (edge_s[2]) pc_r <= pc_r + 12'd1;
          else if (edge_s[1]) pc_r <= sw[11:0];
          else if (edge_s[0]) ac_r <= sw[11:0];
        end
        S_FETCH: state_r <= S_EA;
        S_EA: begin
          ir_r <= rdata_r;
          mb_r <= rdata_r;
          pc_r <= pc_r + 12'd1;
          ea_r <= base_s;
          if (rdata_r[11:10] == 2'b11) state_r <= S_MIC;
          else if (rdata_r[8]) state_r <= S_IND;
          else begin
            case (rdata_r[11:9])
              3'd0:    state_r <= S_AND;
              3'd1:    state_r <= S_TAD;
              3'd2:    state_r <= S_ISZ1;
              3'd3:    state_r <= S_DCA;
              3'd4:    state_r <= S_JMS1;
              default: state_r <= S_JMP;
            endcase
          end
        end
        S_IND: begin
          ea_r <= auto_s ? (rdata_r + 12'd1) : rdata_r;
          case (ir_r[11:9])
            3'd0, 3'd1, 3'd2: state_r <= S_RD;
            3'd3:             state_r <= S_DCA;
            3'd4:             state_r <= S_JMS1;
            default:          state_r <= S_JMP;
          endcase
        end
        S_RD: begin
          case (ir_r[11:9])
            3'd0:    state_r <= S_AND;
            3'd1:    state_r <= S_TAD;
            default: state_r <= S_ISZ1;
          endcase
        end
        S_AND: ac_r <= ac_r & rdata_r;
        S_TAD: begin
          ac_r   <= tad_s[11:0];
          link_r <= link_r ^ tad_s[12];
        end
        S_ISZ1: begin
          mb_r    <= rdata_r + 12'd1;
          state_r <= S_ISZ2;
        end
        S_ISZ2: if (mb_r == 12'd0) pc_r <= pc_r + 12'd1;
        S_DCA:  ac_r <= 12'd0;
        S_JMS1: state_r <= S_JMS2;
        S_JMS2: pc_r <= ea_r + 12'd1;
        S_JMP:  pc_r <= ea_r;
        S_MIC: begin
          if (ir_r[11:9] == 3'd7) begin
            if (!ir_r[8]) begin
              {link_r, ac_r} <= g1_s;
            end else if (!ir_r[0]) begin
              if (skip_s) pc_r <= pc_r + 12'd1;
              ac_r <= g2_ac_s;
            end else begin
              case ({ir_r[6], ir_r[4]})
                2'b11: begin
                  ac_r <= mq_r;
                  mq_r <= cla_ac_s;
                end
                2'b10: ac_r <= cla_ac_s | mq_r;
                2'b01: begin
                  mq_r <= cla_ac_s;
                  ac_r <= 12'd0;
                end
                default: ac_r <= cla_ac_s;
              endcase
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
      // Completion overrides any state set above
      if (fin_s) begin
        state_r <= S_IDLE;
        done_r  <= 1'b1;
        if (!sw[12] || hlt_s) run_r <= 1'b0;
      end
    end
  end

  // Digit selection for the lower four display positions
  always_comb begin
    disp_val_s = disp_sel_r ? ac_r : pc_r;
    case (scan_r[15:14])
      2'd0:    begin digit_s = disp_val_s[2:0];  an_s = 8'hFE; end
      2'd1:    begin digit_s = disp_val_s[5:3];  an_s = 8'hFD; end
      2'd2:    begin digit_s = disp_val_s[8:6];  an_s = 8'hFB; end
      default: begin digit_s = disp_val_s[11:9]; an_s = 8'hF7; end
    endcase
  end

  // Display scan counter and registered digit/segment drive
  always_ff @(posedge clk) begin
    if (btnCpuReset) begin
      scan_r <= 16'd0;
      an     <= 8'hFF;
      seg    <= 7'h7F;
    end else begin
      scan_r <= scan_r + 16'd1;
      an     <= an_s;
      seg    <= glyph(digit_s);
    end
  end

  assign led = {1'b0, link_r, done_r, run_r, ac_r};
  assign dp  = 1'b1;

endmodule

// File: tb/tb_pdp8_top.sv
// tb_pdp8_top: directed tests for pdp8_top through the front panel.
module tb_pdp8_top;

  logic        clk = 1'b0;
  logic        btnCpuReset = 1'b1;
  logic        btnc = 1'b0, btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0;
  logic [12:0] sw = 13'd0;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int errors = 0;
  int checks = 0;

  logic [6:0] glyph_tab [0:7];

  pdp8_top dut (
    .clk(clk), .btnCpuReset(btnCpuReset), .btnc(btnc), .btnu(btnu),
    .btnd(btnd), .btnl(btnl), .btnr(btnr), .sw(sw),
    .led(led), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btnCpuReset = 1'b1;
    tick(3);
    btnCpuReset = 1'b0;
    tick(1);
  endtask

  // 0=btnr 1=btnl 2=btnd 3=btnu 4=btnc
  task automatic press(input int which);
    case (which)
      0: btnr = 1'b1;
      1: btnl = 1'b1;
      2: btnd = 1'b1;
      3: btnu = 1'b1;
      default: btnc = 1'b1;
    endcase
    tick(3);
    {btnc, btnu, btnd, btnl, btnr} = 5'd0;
    tick(2);
  endtask

  task automatic load_pc(input logic [11:0] v);
    sw[11:0] = v;
    press(1);
  endtask

  task automatic load_ac(input logic [11:0] v);
    sw[11:0] = v;
    press(0);
  endtask

  task automatic deposit(input logic [11:0] v);
    sw[11:0] = v;
    press(2);
  endtask

  task automatic step_instr();
    bit seen;
    seen = 1'b0;
    btnu = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) btnu = 1'b0;
      if (led[13]) begin
        seen = 1'b1;
        break;
      end
    end
    btnu = 1'b0;
    tick(2);
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL step_done: led13 pulse got %0b need 1", seen);
    end
  endtask

  task automatic test_reset();
    btnCpuReset = 1'b1;
    tick(3);
    checks++; if (led !== 16'd0) begin errors++; $display("FAIL reset_led: got %h need 0000", led); end
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h need ff", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h need 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b need 1", dp); end
    btnCpuReset = 1'b0;
    tick(3);
    checks++; if (dut.pc_r !== 12'd0) begin errors++; $display("FAIL reset_pc: got %o need 0", dut.pc_r); end
    checks++; if (dut.mq_r !== 12'd0) begin errors++; $display("FAIL reset_mq: got %o need 0", dut.mq_r); end
    checks++; if ($countones(~an) != 1) begin errors++; $display("FAIL scan_onehot: an got %h need one low bit", an); end
  endtask

  task automatic test_deposit();
    load_pc(12'o0200);
    deposit(12'o7200);
    deposit(12'o7402);
    checks++; if (dut.mem_r[12'o0200] !== 12'o7200) begin errors++; $display("FAIL dep_mem200: got %o need 7200", dut.mem_r[12'o0200]); end
    checks++; if (dut.mem_r[12'o0201] !== 12'o7402) begin errors++; $display("FAIL dep_mem201: got %o need 7402", dut.mem_r[12'o0201]); end
    checks++; if (dut.valid_r[12'o0200] !== 1'b1 || dut.valid_r[12'o0201] !== 1'b1) begin errors++; $display("FAIL dep_valid: got %b%b need 11", dut.valid_r[12'o0200], dut.valid_r[12'o0201]); end
    checks++; if (dut.pc_r !== 12'o0202) begin errors++; $display("FAIL dep_pc: got %o need 0202", dut.pc_r); end
  endtask

  task automatic test_run_halt();
    int pulses;
    logic run_at1, run_at2;
    pulses = 0; run_at1 = 1'b0; run_at2 = 1'b1;
    load_ac(12'o5555);
    load_pc(12'o0200);
    sw[12] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (led[13]) begin
        pulses++;
        if (pulses == 1) run_at1 = led[12];
        if (pulses == 2) run_at2 = led[12];
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL run_pulses: got %0d need 2", pulses); end
    checks++; if (run_at1 !== 1'b1) begin errors++; $display("FAIL run_first: led12 got %b need 1", run_at1); end
    checks++; if (run_at2 !== 1'b0) begin errors++; $display("FAIL run_halt_fall: led12 got %b need 0", run_at2); end
    checks++; if (led[11:0] !== 12'o0000) begin errors++; $display("FAIL run_ac: got %o need 0", led[11:0]); end
    checks++; if (led[12] !== 1'b0) begin errors++; $display("FAIL run_stopped: got %b need 0", led[12]); end
    sw[12] = 1'b0;
    tick(2);
  endtask

  task automatic test_arith();
    do_reset();
    load_pc(12'o0310); deposit(12'o7777); deposit(12'o0001);
    load_pc(12'o0300); deposit(12'o1310); deposit(12'o1311); deposit(12'o7041);
    load_pc(12'o0300);
    step_instr();
    checks++; if (led[14:0] !== {1'b0, 2'b00, 12'o7777}) begin errors++; $display("FAIL tad1: L/AC got %o need 0/7777", led[14:0]); end
    step_instr();
    checks++; if (led[11:0] !== 12'o0000) begin errors++; $display("FAIL tad2_ac: got %o need 0", led[11:0]); end
    checks++; if (led[14] !== 1'b1) begin errors++; $display("FAIL tad2_link: got %b need 1", led[14]); end
    step_instr();
    checks++; if (led[11:0] !== 12'o0000 || led[14] !== 1'b0) begin errors++; $display("FAIL cma_iac: L/AC got %b/%o need 0/0", led[14], led[11:0]); end
    checks++; if (dut.pc_r !== 12'o0303) begin errors++; $display("FAIL arith_pc: got %o need 0303", dut.pc_r); end
  endtask

  task automatic test_isz_skip();
    load_pc(12'o0320);
    deposit(12'o7777); deposit(12'o0005); deposit(12'o2320); deposit(12'o7000);
    deposit(12'o2321); deposit(12'o7440); deposit(12'o7000); deposit(12'o7450);
    deposit(12'o7000);
    do_reset();
    load_pc(12'o0322);
    step_instr();
    checks++; if (dut.mem_r[12'o0320] !== 12'o0000) begin errors++; $display("FAIL isz_word: got %o need 0", dut.mem_r[12'o0320]); end
    checks++; if (dut.valid_r[12'o0320] !== 1'b1) begin errors++; $display("FAIL isz_valid: got %b need 1", dut.valid_r[12'o0320]); end
    checks++; if (dut.valid_r[12'o0322] !== 1'b0) begin errors++; $display("FAIL unwritten_valid: got %b need 0", dut.valid_r[12'o0322]); end
    checks++; if (dut.pc_r !== 12'o0324) begin errors++; $display("FAIL isz_skip_pc: got %o need 0324", dut.pc_r); end
    step_instr();
    checks++; if (dut.mem_r[12'o0321] !== 12'o0006 || dut.pc_r !== 12'o0325) begin errors++; $display("FAIL isz_noskip: word/pc got %o/%o need 0006/0325", dut.mem_r[12'o0321], dut.pc_r); end
    step_instr();
    checks++; if (dut.pc_r !== 12'o0327) begin errors++; $display("FAIL sza_skip: pc got %o need 0327", dut.pc_r); end
    step_instr();
    checks++; if (dut.pc_r !== 12'o0330) begin errors++; $display("FAIL sna_noskip: pc got %o need 0330", dut.pc_r); end
  endtask

  task automatic test_jms_ind();
    load_pc(12'o0200); deposit(12'o4300);
    load_pc(12'o0301); deposit(12'o1410);
    load_pc(12'o0010); deposit(12'o0377);
    load_pc(12'o0400); deposit(12'o0123);
    load_ac(12'o0000);
    load_pc(12'o0200);
    step_instr();
    checks++; if (dut.mem_r[12'o0300] !== 12'o0201) begin errors++; $display("FAIL jms_link: got %o need 0201", dut.mem_r[12'o0300]); end
    checks++; if (dut.pc_r !== 12'o0301) begin errors++; $display("FAIL jms_pc: got %o need 0301", dut.pc_r); end
    step_instr();
    checks++; if (led[11:0] !== 12'o0123) begin errors++; $display("FAIL autoidx_ac: got %o need 0123", led[11:0]); end
    checks++; if (dut.mem_r[12'o0010] !== 12'o0400) begin errors++; $display("FAIL autoidx_ptr: got %o need 0400", dut.mem_r[12'o0010]); end
    checks++; if (dut.pc_r !== 12'o0302) begin errors++; $display("FAIL autoidx_pc: got %o need 0302", dut.pc_r); end
  endtask

  task automatic test_group3();
    load_pc(12'o0500); deposit(12'o7421); deposit(12'o7200); deposit(12'o7521);
    load_ac(12'o1234);
    load_pc(12'o0500);
    step_instr();
    checks++; if (led[11:0] !== 12'o0000 || dut.mq_r !== 12'o1234) begin errors++; $display("FAIL mql: AC/MQ got %o/%o need 0000/1234", led[11:0], dut.mq_r); end
    step_instr();
    step_instr();
    checks++; if (led[11:0] !== 12'o1234 || dut.mq_r !== 12'o0000) begin errors++; $display("FAIL swp: AC/MQ got %o/%o need 1234/0000", led[11:0], dut.mq_r); end
  endtask

  task automatic test_display();
    logic [11:0] val;
    int d;
    logic [11:0] sh;
    for (int pass = 0; pass < 2; pass++) begin
      val = (pass == 0) ? 12'o0503 : 12'o1234;
      if (pass == 1) press(4);
      tick(1);
      d = -1;
      for (int k = 0; k < 4; k++) if (an[k] == 1'b0) d = k;
      checks++;
      if (d < 0 || an[7:4] !== 4'hF || $countones(~an) != 1) begin
        errors++; $display("FAIL disp_an: got %h need one low bit in [3:0]", an);
      end else begin
        sh = val >> (3 * d);
        checks++;
        if (seg !== glyph_tab[sh[2:0]]) begin
          errors++; $display("FAIL disp_seg%0d: digit %0d got %h need %h", pass, d, seg, glyph_tab[sh[2:0]]);
        end
      end
    end
  endtask

  task automatic test_abort();
    load_pc(12'o0610); deposit(12'o0000);
    load_pc(12'o0600); deposit(12'o3210);
    load_ac(12'o7777);
    load_pc(12'o0600);
    btnu = 1'b1;
    tick(2);
    btnCpuReset = 1'b1;
    btnu = 1'b0;
    tick(3);
    btnCpuReset = 1'b0;
    tick(2);
    checks++; if (dut.mem_r[12'o0610] !== 12'o0000) begin errors++; $display("FAIL abort_write: got %o need 0", dut.mem_r[12'o0610]); end
    checks++; if (led !== 16'd0) begin errors++; $display("FAIL abort_led: got %h need 0000", led); end
  endtask

  initial begin
    glyph_tab[0] = 7'h40; glyph_tab[1] = 7'h79; glyph_tab[2] = 7'h24; glyph_tab[3] = 7'h30;
    glyph_tab[4] = 7'h19; glyph_tab[5] = 7'h12; glyph_tab[6] = 7'h02; glyph_tab[7] = 7'h78;
    test_reset();
    test_deposit();
    test_run_halt();
    test_arith();
    test_isz_skip();
    test_jms_ind();
    test_group3();
    test_display();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
